// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory-stage access and turns it into a single
// word-aligned request on a simple req/ready memory port. Loads are returned
// lane-extracted and sign/zero extended; stores are lane-replicated with byte
// enables. Misaligned or illegal accesses are rejected with a one-cycle error
// pulse, and a stuck memory is abandoned after TIMEOUT request cycles.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        stall,
    output logic        access_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // The wait counter only has to reach TIMEOUT-1, so it is sized for that.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h00_0000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = word;
            default: r = word;
        endcase
        return r;
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [3:0] r;
        case (f3[1:0])
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = 4'b0011 << off;
            2'b10:   r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Replicate store data across all lanes so memory can take any enabled lane.
    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] wait_cnt_r;
    logic          we_r;
    logic [2:0]    f3_r;
    logic [1:0]    off_r;
    logic [3:0]    be_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   read_data_r;
    logic          err_r;

    logic          f3_ok_s;
    logic          align_ok_s;
    logic          valid_s;
    logic          any_s;
    logic          start_s;
    logic          bad_s;
    logic          timeout_s;

    // Classify the presented access: legal size and naturally aligned.
    always_comb begin
        f3_ok_s    = 1'b0;
        align_ok_s = 1'b0;
        case (funct3)
            3'b000, 3'b100: begin
                f3_ok_s    = 1'b1;
                align_ok_s = 1'b1;
            end
            3'b001, 3'b101: begin
                f3_ok_s    = 1'b1;
                align_ok_s = ~Address[0];
            end
            3'b010: begin
                f3_ok_s    = 1'b1;
                align_ok_s = (Address[1:0] == 2'b00);
            end
            default: begin
                f3_ok_s    = 1'b0;
                align_ok_s = 1'b0;
            end
        endcase
    end

    assign any_s     = MemRead | MemWrite;
    assign valid_s   = (MemRead ^ MemWrite) & f3_ok_s & align_ok_s;
    assign start_s   = (state_r == IDLE) & valid_s;
    assign bad_s     = (state_r == IDLE) & any_s & ~valid_s;
    assign timeout_s = TO_EN & (wait_cnt_r == TO_LAST) & ~mem_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; DONE always returns to IDLE so the same instruction is not reissued.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_s) begin
                    state_nx_s = REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ready || timeout_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = REQ;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode; stall rises in the accepting IDLE cycle so the pipeline freezes at once.
    always_comb begin
        stall   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_be  = 4'b0000;
        case (state_r)
            IDLE: begin
                stall = start_s & rst_n;
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = we_r;
                mem_be  = be_r;
            end
            DONE: begin
                stall = 1'b0;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Capture the access on acceptance so the memory port stays stable during REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            off_r   <= 2'b00;
            be_r    <= 4'b0000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (start_s) begin
            we_r    <= MemWrite;
            f3_r    <= funct3;
            off_r   <= Address[1:0];
            be_r    <= MemWrite ? store_be(funct3, Address[1:0]) : 4'b0000;
            addr_r  <= {Address[31:2], 2'b00};
            wdata_r <= store_wdata(funct3, Write_data);
        end else begin
            we_r    <= we_r;
            f3_r    <= f3_r;
            off_r   <= off_r;
            be_r    <= be_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Count REQ cycles without a response; cleared as the request is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (start_s) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (state_r == REQ) begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Load result is updated only by a load completing; stores and aborts leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_r <= 32'h0000_0000;
        end else if ((state_r == REQ) && mem_ready && !we_r) begin
            read_data_r <= load_extract(f3_r, off_r, mem_rdata);
        end else begin
            read_data_r <= read_data_r;
        end
    end

    // Error pulse: after a rejected access, or in DONE after a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= bad_s | ((state_r == REQ) & timeout_s);
        end
    end

    assign Read_data  = read_data_r;
    assign access_err = err_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: default-TIMEOUT instance for the data paths and
// a TIMEOUT=4 instance for the abort path. Expected load results go into a
// scoreboard queue at issue and are compared when the access completes.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] read_data;
    logic        stall;
    logic        access_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    logic        to_mem_read;
    logic        to_mem_write;
    logic        to_mem_ready;
    logic [31:0] to_read_data;
    logic        to_stall;
    logic        to_access_err;
    logic        to_mem_req;
    logic        to_mem_we;
    logic [31:0] to_mem_addr;
    logic [31:0] to_mem_wdata;
    logic [3:0]  to_mem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0000_0000;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
        .funct3(funct3), .Address(address), .Write_data(write_data),
        .Read_data(read_data), .stall(stall), .access_err(access_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .MemRead(to_mem_read), .MemWrite(to_mem_write),
        .funct3(funct3), .Address(address), .Write_data(write_data),
        .Read_data(to_read_data), .stall(to_stall), .access_err(to_access_err),
        .mem_req(to_mem_req), .mem_we(to_mem_we), .mem_addr(to_mem_addr),
        .mem_wdata(to_mem_wdata), .mem_be(to_mem_be), .mem_ready(to_mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        address = 32'h0; write_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        to_mem_read = 1'b0; to_mem_write = 1'b0; to_mem_ready = 1'b0;
        #2;
        checks++;
        if ({read_data, stall, access_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 104'h0) begin
            errors++;
            $display("FAIL reset_state: got rd=%h stall=%b err=%b req=%b we=%b be=%b addr=%h wd=%h, want all zero",
                     read_data, stall, access_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One valid access; ready is returned after 'delay' idle REQ cycles.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int delay, input logic [31:0] exp_rd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int  n_stall = 0;
        int  n_req   = 0;
        bit  done    = 1'b0;
        logic [31:0] want;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; address = addr; write_data = wd;
        mem_ready = 1'b0;
        exp_q.push_back(rd ? exp_rd : last_rd);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (c == 0) begin
                checks++;
                if (mem_req !== 1'b0 || mem_be !== 4'b0000 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_idle_port: req=%b be=%b we=%b, want 0/0000/0", name, mem_req, mem_be, mem_we);
                end
            end
            if (mem_req) begin
                n_req++;
                checks++;
                if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== wr || mem_be !== exp_be ||
                    (wr && mem_wdata !== exp_wd)) begin
                    errors++;
                    $display("FAIL %s_req_port: addr=%h we=%b be=%b wd=%h, want %h/%b/%b/%h",
                             name, mem_addr, mem_we, mem_be, mem_wdata, {addr[31:2], 2'b00}, wr, exp_be, exp_wd);
                end
                mem_ready = (n_req > delay);
                mem_rdata = (n_req > delay) ? rdata : 32'hxxxx_xxxx;
            end else if (n_req > 0) begin
                done = 1'b1;
                mem_ready = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_complete: access did not finish in 40 cycles, want completion", name);
        end
        checks++;
        if (n_stall != delay + 2 || n_req != delay + 1) begin
            errors++;
            $display("FAIL %s_latency: stall=%0d req=%0d cycles, want %0d/%0d", name, n_stall, n_req, delay + 2, delay + 1);
        end
        want = exp_q.pop_front();
        checks++;
        if (read_data !== want) begin
            errors++;
            $display("FAIL %s_read_data: got %h, want %h", name, read_data, want);
        end
        last_rd = want;
    endtask

    task automatic test_loads();
        do_access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 0, 32'hFFFF_FF80, 4'b0000, 32'h0);
        do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 5, 32'h0000_BEEF, 4'b0000, 32'h0);
        do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_5001, 32'h0, 32'h1234_8A56, 1, 32'h0000_008A, 4'b0000, 32'h0);
        do_access("lh",  1'b1, 1'b0, 3'b001, 32'h0000_6000, 32'h0, 32'h0000_9ABC, 0, 32'hFFFF_9ABC, 4'b0000, 32'h0);
        do_access("lw",  1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'b0000, 32'h0);
        idle_bus();
    endtask

    task automatic test_stores();
        do_access("sh", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 32'h0, 4'b1100, 32'hABCD_ABCD);
        do_access("sb", 1'b0, 1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5, 32'h5555_5555, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5);
        do_access("sw", 1'b0, 1'b1, 3'b010, 32'h0000_9000, 32'h0123_4567, 32'h5555_5555, 0, 32'h0, 4'b1111, 32'h0123_4567);
        idle_bus();
    endtask

    task automatic test_back_to_back();
        do_access("b2b_lb", 1'b1, 1'b0, 3'b000, 32'h0000_A000, 32'h0, 32'h0000_007F, 0, 32'h0000_007F, 4'b0000, 32'h0);
        do_access("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h0000_A004, 32'hCAFE_F00D, 32'h0, 0, 32'h0, 4'b1111, 32'hCAFE_F00D);
        do_access("b2b_lh", 1'b1, 1'b0, 3'b001, 32'h0000_A006, 32'h0, 32'h8001_0000, 0, 32'hFFFF_8001, 4'b0000, 32'h0);
        idle_bus();
    endtask

    // Rejected access: one error pulse the next cycle, no request, no stall.
    task automatic do_invalid(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        bit saw_req = 1'b0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; address = addr;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: got %b, want 0", name, stall);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        if (mem_req) saw_req = 1'b1;
        @(negedge clk);
        checks++;
        if (access_err !== 1'b1) begin
            errors++;
            $display("FAIL %s_err_pulse: got %b, want 1", name, access_err);
        end
        if (mem_req) saw_req = 1'b1;
        @(negedge clk);
        checks++;
        if (access_err !== 1'b0 || saw_req || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_err_end: err=%b req_seen=%b, want 0/0", name, access_err, saw_req | mem_req);
        end
        checks++;
        if (read_data !== last_rd) begin
            errors++;
            $display("FAIL %s_read_data: got %h, want %h", name, read_data, last_rd);
        end
    endtask

    task automatic test_invalid();
        do_invalid("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h0000_3001);
        do_invalid("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h0000_2001);
        do_invalid("bad_funct3",  1'b1, 1'b0, 3'b011, 32'h0000_3000);
        do_invalid("rd_and_wr",   1'b1, 1'b1, 3'b000, 32'h0000_3000);
    endtask

    task automatic test_timeout();
        int  n_req = 0;
        bit  done  = 1'b0;
        @(posedge clk); #1;
        to_mem_read = 1'b1; funct3 = 3'b010; address = 32'h0000_B000; to_mem_ready = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (to_mem_req) n_req++;
            else if (n_req > 0) done = 1'b1;
        end
        checks++;
        if (!done || n_req != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d (done=%b), want 4", n_req, done);
        end
        checks++;
        if (to_access_err !== 1'b1 || to_stall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_in_done: err=%b stall=%b, want 1/0", to_access_err, to_stall);
        end
        @(posedge clk); #1;
        to_mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (to_access_err !== 1'b0 || to_mem_req !== 1'b0 || to_stall !== 1'b0 || to_read_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_back_idle: err=%b req=%b stall=%b rd=%h, want 0/0/0/0",
                     to_access_err, to_mem_req, to_stall, to_read_data);
        end
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; address = 32'h0000_C004;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_req: req=%b stall=%b, want 1/1", mem_req, stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({read_data, stall, access_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 104'h0) begin
            errors++;
            $display("FAIL rst_mid_req: rd=%h stall=%b err=%b req=%b we=%b be=%b addr=%h wd=%h, want all zero",
                     read_data, stall, access_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_retry: cycle %0d req=%b stall=%b, want 0/0", c, mem_req, stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_invalid();
        test_back_to_back();
        test_timeout();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
